// File: rtl/sram_scan_host.sv
// Scan-chain initiator for the SRAM test unit: serializes control words into the control chain,
// deserializes the dout chain, and generates scan_clk / scan enables / scan reset from clk.
module sram_scan_host #(
    parameter int unsigned CTL_WIDTH  = 42,
    parameter int unsigned DOUT_WIDTH = 32,
    parameter int unsigned DIV        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [CTL_WIDTH-1:0]  cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DOUT_WIDTH-1:0] rsp_data,
    output logic                  scan_clk,
    output logic                  ctl_scan_en,
    output logic                  ctl_scan_rstb,
    output logic                  ctl_scan_in,
    output logic                  dout_scan_en,
    input  logic                  dout_scan_out
);

    localparam int unsigned MaxW = (CTL_WIDTH > DOUT_WIDTH) ? CTL_WIDTH : DOUT_WIDTH;
    localparam int unsigned BitW = (MaxW > 1) ? $clog2(MaxW) : 1;
    localparam int unsigned PhW  = $clog2(DIV + 1);

    localparam logic [PhW-1:0]  PhLast  = PhW'(DIV - 1);
    localparam logic [BitW-1:0] CtlTop  = BitW'(CTL_WIDTH - 1);
    localparam logic [BitW-1:0] DoutTop = BitW'(DOUT_WIDTH - 1);

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpRst  = 2'd1;
    localparam logic [1:0] OpLoad = 2'd2;
    localparam logic [1:0] OpRead = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StShiftLo,
        StShiftHi,
        StResp
    } state_e;

    state_e                r_state, w_state_d;
    logic [1:0]            r_op, w_op_d;
    logic [PhW-1:0]        r_phase, w_phase_d;
    logic [BitW-1:0]       r_bit, w_bit_d;
    logic [CTL_WIDTH-1:0]  r_shadow, w_shadow_d;
    logic [DOUT_WIDTH-1:0] r_rsp_data, w_rsp_data_d;
    logic                  r_cmd_ready, w_cmd_ready_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic                  r_scan_clk, w_scan_clk_d;
    logic                  r_ctl_en, w_ctl_en_d;
    logic                  r_ctl_rstb, w_ctl_rstb_d;
    logic                  r_dout_en, w_dout_en_d;

    logic w_accept;
    logic w_phase_last;
    logic w_is_read;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_phase_last = (r_phase == PhLast);
    assign w_is_read    = (r_op == OpRead);

    always_comb begin
        w_state_d     = r_state;
        w_op_d        = r_op;
        w_phase_d     = r_phase;
        w_bit_d       = r_bit;
        w_shadow_d    = r_shadow;
        w_rsp_data_d  = r_rsp_data;
        w_cmd_ready_d = r_cmd_ready;
        w_rsp_valid_d = r_rsp_valid;
        w_scan_clk_d  = r_scan_clk;
        w_ctl_en_d    = r_ctl_en;
        w_ctl_rstb_d  = r_ctl_rstb;
        w_dout_en_d   = r_dout_en;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_op_d    = cmd_op;
                    w_phase_d = '0;
                    case (cmd_op)
                        OpRst: begin
                            // r_bit counts the two DIV-long halves of the reset pulse
                            w_state_d     = StRst;
                            w_cmd_ready_d = 1'b0;
                            w_ctl_rstb_d  = 1'b0;
                            w_bit_d       = BitW'(1);
                        end
                        OpLoad: begin
                            // Shadow only reloads for LOAD so ctl_scan_in stays quiet otherwise
                            w_state_d     = StShiftLo;
                            w_cmd_ready_d = 1'b0;
                            w_ctl_en_d    = 1'b1;
                            w_shadow_d    = cmd_data;
                            w_bit_d       = CtlTop;
                        end
                        OpRead: begin
                            w_state_d     = StShiftLo;
                            w_cmd_ready_d = 1'b0;
                            w_dout_en_d   = 1'b1;
                            w_bit_d       = DoutTop;
                        end
                        default: ;
                    endcase
                end
            end

            StRst: begin
                if (w_phase_last) begin
                    w_phase_d = '0;
                    if (r_bit == '0) begin
                        w_state_d     = StIdle;
                        w_ctl_rstb_d  = 1'b1;
                        w_cmd_ready_d = 1'b1;
                    end else begin
                        w_bit_d = r_bit - BitW'(1);
                    end
                end else begin
                    w_phase_d = r_phase + PhW'(1);
                end
            end

            StShiftLo: begin
                if (w_phase_last) begin
                    // Last low cycle: capture dout before scan_clk rises
                    if (w_is_read) begin
                        w_rsp_data_d = (r_rsp_data << 1) | DOUT_WIDTH'(dout_scan_out);
                    end
                    w_state_d    = StShiftHi;
                    w_scan_clk_d = 1'b1;
                    w_phase_d    = '0;
                end else begin
                    w_phase_d = r_phase + PhW'(1);
                end
            end

            StShiftHi: begin
                if (w_phase_last) begin
                    w_phase_d    = '0;
                    w_scan_clk_d = 1'b0;
                    if (r_bit == '0) begin
                        w_ctl_en_d  = 1'b0;
                        w_dout_en_d = 1'b0;
                        if (w_is_read) begin
                            w_state_d     = StResp;
                            w_rsp_valid_d = 1'b1;
                        end else begin
                            w_state_d     = StIdle;
                            w_cmd_ready_d = 1'b1;
                        end
                    end else begin
                        w_state_d = StShiftLo;
                        w_bit_d   = r_bit - BitW'(1);
                        if (!w_is_read) begin
                            w_shadow_d = r_shadow << 1;
                        end
                    end
                end else begin
                    w_phase_d = r_phase + PhW'(1);
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    w_state_d     = StIdle;
                    w_rsp_valid_d = 1'b0;
                    w_cmd_ready_d = 1'b1;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= OpNop;
            r_phase     <= '0;
            r_bit       <= '0;
            r_shadow    <= '0;
            r_rsp_data  <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_scan_clk  <= 1'b0;
            r_ctl_en    <= 1'b0;
            r_ctl_rstb  <= 1'b1;
            r_dout_en   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_op        <= w_op_d;
            r_phase     <= w_phase_d;
            r_bit       <= w_bit_d;
            r_shadow    <= w_shadow_d;
            r_rsp_data  <= w_rsp_data_d;
            r_cmd_ready <= w_cmd_ready_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_scan_clk  <= w_scan_clk_d;
            r_ctl_en    <= w_ctl_en_d;
            r_ctl_rstb  <= w_ctl_rstb_d;
            r_dout_en   <= w_dout_en_d;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign scan_clk      = r_scan_clk;
    assign ctl_scan_en   = r_ctl_en;
    assign ctl_scan_rstb = r_ctl_rstb;
    assign ctl_scan_in   = r_shadow[CTL_WIDTH-1];
    assign dout_scan_en  = r_dout_en;

endmodule

// File: tb/tb_sram_scan_host.sv
// Directed bench for sram_scan_host: DIV=2 instance for timing/data tests, DIV=1 instance for
// back-to-back sequencing, each with behavioural control and dout chain models.
module tb_sram_scan_host;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Instance A (DIV = 2) ----------------
    logic        a_valid = 1'b0, a_ready, a_rsp_valid, a_rsp_ready = 1'b0;
    logic [1:0]  a_op = 2'd0;
    logic [41:0] a_data = '0;
    logic [31:0] a_rsp_data;
    logic        a_sclk, a_ctl_en, a_rstb, a_ctl_in, a_dout_en, a_dout_out;

    sram_scan_host #(.CTL_WIDTH(42), .DOUT_WIDTH(32), .DIV(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op), .cmd_data(a_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .scan_clk(a_sclk), .ctl_scan_en(a_ctl_en), .ctl_scan_rstb(a_rstb),
        .ctl_scan_in(a_ctl_in), .dout_scan_en(a_dout_en), .dout_scan_out(a_dout_out)
    );

    logic [41:0] a_ctl_chain = '0;
    logic [31:0] a_dout_chain = '0, a_pre = '0;
    logic        a_load = 1'b0, a_sc_prev = 1'b0;
    int          a_edges = 0;
    assign a_dout_out = a_dout_chain[31];

    // Chains advance on the first negedge after a scan_clk rise (race-free with the DUT)
    always @(negedge clk) begin
        a_sc_prev <= a_sclk;
        if (a_sclk && !a_sc_prev) begin
            a_edges <= a_edges + 1;
            if (a_ctl_en) a_ctl_chain <= {a_ctl_chain[40:0], a_ctl_in};
        end
        if (a_load) a_dout_chain <= a_pre;
        else if (a_sclk && !a_sc_prev && a_dout_en) a_dout_chain <= {a_dout_chain[30:0], 1'b0};
    end

    // ---------------- Instance B (DIV = 1) ----------------
    logic        b_valid = 1'b0, b_ready, b_rsp_valid, b_rsp_ready = 1'b0;
    logic [1:0]  b_op = 2'd0;
    logic [41:0] b_data = '0;
    logic [31:0] b_rsp_data;
    logic        b_sclk, b_ctl_en, b_rstb, b_ctl_in, b_dout_en, b_dout_out;

    sram_scan_host #(.CTL_WIDTH(42), .DOUT_WIDTH(32), .DIV(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op), .cmd_data(b_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .scan_clk(b_sclk), .ctl_scan_en(b_ctl_en), .ctl_scan_rstb(b_rstb),
        .ctl_scan_in(b_ctl_in), .dout_scan_en(b_dout_en), .dout_scan_out(b_dout_out)
    );

    logic [41:0] b_ctl_chain = '0;
    logic [31:0] b_dout_chain = '0, b_pre = '0;
    logic        b_load = 1'b0, b_sc_prev = 1'b0;
    int          b_edges = 0;
    assign b_dout_out = b_dout_chain[31];

    always @(negedge clk) begin
        b_sc_prev <= b_sclk;
        if (b_sclk && !b_sc_prev) begin
            b_edges <= b_edges + 1;
            if (b_ctl_en) b_ctl_chain <= {b_ctl_chain[40:0], b_ctl_in};
        end
        if (b_load) b_dout_chain <= b_pre;
        else if (b_sclk && !b_sc_prev && b_dout_en) b_dout_chain <= {b_dout_chain[30:0], 1'b0};
    end

    // ---------------- Helpers ----------------
    task automatic issue_a(input logic [1:0] op, input logic [41:0] data);
        a_valid = 1'b1;
        a_op    = op;
        a_data  = data;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic preload_a(input logic [31:0] v);
        a_pre  = v;
        a_load = 1'b1;
        @(negedge clk);
        #1;
        a_load = 1'b0;
        tick();
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".cmd_ready"}, 64'(a_ready), 64'd1);
        check({tag, ".rsp_valid"}, 64'(a_rsp_valid), 64'd0);
        check({tag, ".rsp_data"}, 64'(a_rsp_data), 64'd0);
        check({tag, ".scan_clk"}, 64'(a_sclk), 64'd0);
        check({tag, ".ctl_scan_en"}, 64'(a_ctl_en), 64'd0);
        check({tag, ".ctl_scan_rstb"}, 64'(a_rstb), 64'd1);
        check({tag, ".ctl_scan_in"}, 64'(a_ctl_in), 64'd0);
        check({tag, ".dout_scan_en"}, 64'(a_dout_en), 64'd0);
    endtask

    // Runs a READ_DOUT on A; returns busy cycles before rsp_valid
    task automatic read_a(input logic [31:0] v, input string tag);
        int busy;
        int bad;
        preload_a(v);
        issue_a(2'd3, '0);
        busy = 0;
        bad  = 0;
        while (!a_rsp_valid && busy < 1000) begin
            if (a_ready || !a_dout_en) bad++;
            busy++;
            tick();
        end
        check({tag, ".busy"}, 64'(busy), 64'd128);
        check({tag, ".ready_low_en_high"}, 64'(bad), 64'd0);
        check({tag, ".rsp_data"}, 64'(a_rsp_data), 64'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy, bad, viol, e0;
        logic prev_in;
        int cyc, idx;
        int acc_cyc[3];
        logic acc;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check_reset_a("rst");
        rst = 1'b0;
        tick();
        check("rst.ready_after", 64'(a_ready), 64'd1);
        check("rst.b_ready", 64'(b_ready), 64'd1);

        // LOAD_CTL
        e0 = a_edges;
        issue_a(2'd2, 42'h2A5_A5A5_A5A5);
        busy = 0; viol = 0; bad = 0;
        prev_in = a_ctl_in;
        while (!a_ready && busy < 1000) begin
            if (a_sclk && (a_ctl_in != prev_in)) viol++;
            if (!a_ctl_en) bad++;
            prev_in = a_ctl_in;
            busy++;
            tick();
        end
        check("load.busy", 64'(busy), 64'd168);
        check("load.edges", 64'(a_edges - e0), 64'd42);
        check("load.in_stable", 64'(viol), 64'd0);
        check("load.en_held", 64'(bad), 64'd0);
        check("load.chain", 64'(a_ctl_chain), 64'h2A5_A5A5_A5A5);
        check("load.en_drop", 64'(a_ctl_en), 64'd0);
        check("load.sclk_low", 64'(a_sclk), 64'd0);

        // READ_DOUT with response back-pressure
        read_a(32'hDEAD_BEEF, "read");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!a_rsp_valid || a_ready || a_rsp_data !== 32'hDEAD_BEEF) bad++;
        end
        check("read.hold", 64'(bad), 64'd0);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        check("read.valid_drop", 64'(a_rsp_valid), 64'd0);
        check("read.ready_back", 64'(a_ready), 64'd1);
        check("read.data_kept", 64'(a_rsp_data), 64'hDEAD_BEEF);

        // RESET_CTL
        issue_a(2'd1, '0);
        busy = 0; bad = 0;
        while (!a_rstb && busy < 100) begin
            if (a_sclk || a_ctl_en || a_ready) bad++;
            busy++;
            tick();
        end
        check("rstctl.low_cycles", 64'(busy), 64'd4);
        check("rstctl.quiet", 64'(bad), 64'd0);
        check("rstctl.ready_back", 64'(a_ready), 64'd1);

        // rst during the 20th bit of a LOAD_CTL
        issue_a(2'd2, 42'h3FF_0000_FFFF);
        repeat (19 * 4 + 2) tick();
        check("abort.busy_before", 64'(a_ctl_en), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_a("abort");
        rst = 1'b0;
        read_a(32'h1234_5678, "abort_read");
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;

        // Back-to-back on B (DIV = 1): LOAD, READ, NOP with cmd_valid held high
        b_pre  = 32'hCAFE_F00D;
        b_load = 1'b1;
        @(negedge clk);
        #1;
        b_load = 1'b0;
        tick();
        b_rsp_ready = 1'b1;
        b_data  = 42'h155_0F0F_3C3C;
        b_op    = 2'd2;
        b_valid = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 1000) begin
            acc = b_ready;
            if (acc) acc_cyc[idx] = cyc;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 1) b_op = 2'd3;
                else if (idx == 2) b_op = 2'd0;
                else b_valid = 1'b0;
            end
        end
        check("b2b.all_accepted", 64'(idx), 64'd3);
        check("b2b.load_to_read", 64'(acc_cyc[1] - acc_cyc[0]), 64'd85);
        check("b2b.read_to_nop", 64'(acc_cyc[2] - acc_cyc[1]), 64'd66);
        check("b2b.ctl_chain", 64'(b_ctl_chain), 64'h155_0F0F_3C3C);
        check("b2b.rsp_data", 64'(b_rsp_data), 64'hCAFE_F00D);
        e0 = b_edges;
        repeat (10) tick();
        check("b2b.nop_no_sclk", 64'(b_edges - e0), 64'd0);
        check("b2b.nop_ready", 64'(b_ready), 64'd1);
        b_rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_scan_host.md
# sram_scan_host

Scan-chain initiator for the SRAM test unit. It accepts parallel commands from an on-chip controller (or a host bridge) over a valid/ready handshake. It serializes control words into the SRAM control scan chain and deserializes the SRAM dout scan chain into a parallel response. It generates the scan clock, scan enable and scan reset signals that the test unit's scan chains consume, all in the single `clk` domain.

## Interface
Parameters:
- CTL_WIDTH, 42, control chain length (addr + data + we + wmask; 5+32+1+4 for the 32x32m2w8 macro)
- DOUT_WIDTH, 32, dout chain length
- DIV, 2, scan_clk half-period in clk cycles; DIV >= 1

Ports:
- clk  input  1  system clock; all logic is rising-edge clocked
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  0 = NOP, 1 = RESET_CTL, 2 = LOAD_CTL, 3 = READ_DOUT
- cmd_data  input  CTL_WIDTH  word for LOAD_CTL, MSB shifted first
- rsp_valid  output  1  READ_DOUT result available
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  DOUT_WIDTH  captured dout, first-sampled bit at MSB
- scan_clk  output  1  generated scan clock (registered)
- ctl_scan_en, ctl_scan_rstb, ctl_scan_in  output  1 each  control chain drive
- dout_scan_en  output  1  dout chain shift enable
- dout_scan_out  input  1  dout chain serial output

## Operation
- Reset values:
  - cmd_ready = 1
  - rsp_valid = 0
  - rsp_data = 0
  - scan_clk = 0
  - ctl_scan_en = 0
  - ctl_scan_rstb = 1
  - ctl_scan_in = 0
  - dout_scan_en = 0
- Reset mid-operation aborts the command immediately. The next cycle shows reset values, and no partial response is produced.
- States: IDLE, RST, SHIFT_LO, SHIFT_HI, RESP.
- IDLE:
  - cmd_ready = 1.
  - An accepted command (cmd_valid && cmd_ready) latches cmd_op and cmd_data.
  - Next state: RST for op 1, SHIFT_LO for ops 2/3.
  - NOP is accepted and consumed with no effect; the block stays in IDLE.
- RST:
  - ctl_scan_rstb = 0 for 2*DIV cycles; scan_clk stays 0.
  - Then rstb returns to 1 and the block returns to IDLE.
- SHIFT_LO / SHIFT_HI: one scan period per bit.
  - scan_clk = 0 for DIV cycles, then 1 for DIV cycles.
  - The bit counter runs from N-1 down to 0, where N = CTL_WIDTH (LOAD) or DOUT_WIDTH (READ).
- LOAD_CTL:
  - ctl_scan_en = 1 for the whole shift.
  - ctl_scan_in = shadow[N-1] and is stable through the period.
  - The shadow register shifts left by 1 in the same cycle scan_clk falls.
- READ_DOUT:
  - dout_scan_en = 1 for the whole shift.
  - dout_scan_out is sampled in the last low cycle of each period (the cycle before scan_clk rises).
  - The sample is shifted into the LSB of rsp_data, so the first sample ends at the MSB.
- After the last period, scan_clk returns to 0 and the enables drop to 0.
  - LOAD → IDLE.
  - READ → RESP.
- RESP:
  - rsp_valid = 1, rsp_data is held, cmd_ready = 0.
  - When rsp_valid && rsp_ready, the block returns to IDLE (rsp_valid = 0 the next cycle). rsp_data retains its value.
- Only one command is in flight at a time; no command queueing.
- Counter widths: the bit counter is $clog2(max(CTL_WIDTH, DOUT_WIDTH)); the phase counter is $clog2(DIV+1). Both wrap-free by construction.

## Timing
- All outputs are registered. There is no combinational path from cmd_* or rsp_ready to any output.
- Accept at cycle T → first scan-signal change at T+1.
- LOAD_CTL:
  - Busy for 2*DIV*CTL_WIDTH cycles.
  - cmd_ready returns to 1 at T+1+2*DIV*CTL_WIDTH.
  - With defaults: 169 cycles after accept.
- READ_DOUT: rsp_valid rises at T+1+2*DIV*DOUT_WIDTH (129 with defaults).
- RESET_CTL: rstb is low during cycles T+1 .. T+2*DIV; cmd_ready returns at T+1+2*DIV.
- ctl_scan_in, ctl_scan_en and dout_scan_en change only in cycles where scan_clk is 0. This guarantees DIV cycles of setup and hold around each scan_clk rising edge.
- cmd_ready is 0 from T+1 until the return cycle; cmd_valid is ignored while cmd_ready = 0.

## Test plan
- Reset (rst high 3 cycles, then low) → every output equals its listed reset value; cmd_ready = 1 on the first cycle after rst falls.
- LOAD_CTL with cmd_data = 42'h2A5_A5A5_A5A5 (DIV = 2) → a behavioural 42-bit chain model holds exactly that value. Check 42 scan_clk rising edges, cmd_ready = 0 for 168 cycles, and ctl_scan_in stable whenever scan_clk = 1.
- READ_DOUT against a chain model preloaded with 32'hDEAD_BEEF → rsp_valid after 128 busy cycles with rsp_data = 32'hDEAD_BEEF. With rsp_ready held 0 for 10 cycles, rsp_valid and rsp_data are held and cmd_ready = 0.
- RESET_CTL → ctl_scan_rstb low for exactly 4 cycles with scan_clk = 0 throughout; ctl_scan_en stays 0.
- rst asserted at the 20th bit of a LOAD_CTL → next cycle shows reset values; a following READ_DOUT completes normally with correct data.
- Back-to-back: LOAD_CTL, READ_DOUT and NOP offered with cmd_valid held high → each command is accepted only when cmd_ready = 1, in order. NOP causes no scan_clk activity, and sequencing is correct with DIV = 1.
